multi_toggle_gen: RTL and testbench

MULTI_TOGGLE_GEN -- requirements
Module: multi_toggle_gen

---
 rtl/multi_toggle_pkg.sv | 8 +
 rtl/toggle_channel.sv | 51 +++++
 rtl/multi_toggle_gen.sv | 43 ++++
 tb/tb_multi_toggle_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/multi_toggle_pkg.sv
// multi_toggle_pkg: mode encodings and channel period helper for multi_toggle_gen
package multi_toggle_pkg;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;
  function automatic int calc_limit(input int shadow, input int speed_w, input int step);
    return ((1 << speed_w) - shadow) * step;
  endfunction
endpackage

// File: rtl/toggle_channel.sv
// toggle_channel: one output channel counting base ticks up to a speed-derived limit
module toggle_channel
  import multi_toggle_pkg::*;
#(
  parameter int SPEED_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic               tick,
  input  logic               en,
  input  logic               mode,
  input  logic [SPEED_W-1:0] speed,
  output logic               out,
  output logic               wrap
);
  localparam int CW = $clog2((2 ** SPEED_W) * STEP + 1);
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [SPEED_W-1:0] shadow_q, shadow_d;
  logic out_q, out_d, wrap_q, wrap_d, en_q, run, term;
  always_comb begin
    lim      = CW'(calc_limit(int'(shadow_q), SPEED_W, STEP));
    // the cycle en rises only loads the shadow, so the first period is a full one
    run      = en & en_q & ~sync;
    term     = run & tick & (cnt_q == lim - 1'b1);
    cnt_d    = (~run | term) ? '0 : cnt_q + CW'(tick);
    shadow_d = (sync | term | (en & ~en_q)) ? speed : shadow_q;
    wrap_d   = term;
    out_d    = (sync | ~en) ? 1'b0 :
               (mode == MODE_PULSE) ? term :
               (mode == MODE_TOGGLE) ? out_q ^ term : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= 1'b0;
      wrap_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      wrap_q   <= wrap_d;
      en_q     <= en;
    end
  end
  assign out  = out_q;
  assign wrap = wrap_q;
endmodule

// File: rtl/multi_toggle_gen.sv
// multi_toggle_gen: shared prescaler driving N_CH independent toggle/pulse channels
module multi_toggle_gen
  import multi_toggle_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int SPEED_W  = 4,
  parameter int PRESCALE = 50000,
  parameter int STEP     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         mode,
  input  logic [N_CH*SPEED_W-1:0] speed,
  input  logic                    sync,
  output logic [N_CH-1:0]         out,
  output logic [N_CH-1:0]         wrap
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  always_comb begin
    tick  = pre_q == PW'(PRESCALE - 1);
    pre_d = (sync | tick) ? '0 : pre_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    toggle_channel #(.SPEED_W(SPEED_W), .STEP(STEP)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .sync (sync),
      .tick (tick),
      .en   (en[g]),
      .mode (mode[g]),
      .speed(speed[g*SPEED_W +: SPEED_W]),
      .out  (out[g]),
      .wrap (wrap[g])
    );
  end
endmodule

// File: tb/tb_multi_toggle_gen.sv
// tb_multi_toggle_gen: scoreboard bench with a ticks-remaining reference model
module tb_multi_toggle_gen;
  localparam int N_CH = 4, SPEED_W = 4, PRESCALE = 4, STEP = 2;
  logic clk = 1'b0;
  logic rst, sync;
  logic [N_CH-1:0] en, mode, out, wrap;
  logic [N_CH*SPEED_W-1:0] speed;
  always #5 clk = ~clk;
  multi_toggle_gen #(.N_CH(N_CH), .SPEED_W(SPEED_W), .PRESCALE(PRESCALE), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .sync(sync), .out(out), .wrap(wrap)
  );
  int n_vec = 0, n_bad = 0, n_cyc = 0;
  logic [7:0] obs, exp_ow;
  logic [7:0] sb[$];
  int pre = 0;
  int rem[N_CH];
  bit mo[N_CH], mw[N_CH], ep[N_CH];
  function automatic int lim_of(input int s);
    return (2 ** SPEED_W - s) * STEP;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, want);
    end
  endtask
  function automatic void model_step();
    bit tk, term;
    int s;
    tk = (pre == PRESCALE - 1);
    for (int i = 0; i < N_CH; i++) begin
      s = int'(speed[i*SPEED_W +: SPEED_W]);
      term = 1'b0;
      if (rst) begin mo[i] = 0; mw[i] = 0; end
      else if (sync) begin rem[i] = lim_of(s); mo[i] = 0; mw[i] = 0; end
      else if (!en[i]) begin mo[i] = 0; mw[i] = 0; end
      else if (!ep[i]) begin rem[i] = lim_of(s); mw[i] = 0; if (mode[i]) mo[i] = 0; end
      else begin
        term = tk && rem[i] == 1;
        if (tk) rem[i] = term ? lim_of(s) : rem[i] - 1;
        mw[i] = term;
        mo[i] = mode[i] ? term : mo[i] ^ term;
      end
      ep[i] = !rst && en[i];
    end
    pre = (rst || sync || tk) ? 0 : pre + 1;
    for (int i = 0; i < N_CH; i++) begin
      exp_ow[4+i] = mo[i];
      exp_ow[i]   = mw[i];
    end
  endfunction
  task automatic cyc();
    model_step();
    sb.push_back(exp_ow);
    @(posedge clk);
    @(negedge clk);
    n_cyc++;
    obs = {out, wrap};
    chk("cyc", obs, sb.pop_front());
  endtask
  task automatic wait_for(input int idx, input logic v, input string tag, output int dt);
    int t0;
    t0 = n_cyc;
    for (int k = 0; k < 400 && obs[idx] !== v; k++) cyc();
    chk(tag, obs[idx], v);
    dt = n_cyc - t0;
  endtask
  initial begin
    int dt;
    logic acc;
    rst = 1'b1; sync = 1'b0; en = '0; mode = '0; speed = '0;
    repeat (3) begin cyc(); chk("rst_hold", obs, 0); end
    rst = 1'b0; en = 4'b0111; mode = 4'b0010;
    speed = {4'd0, 4'd13, 4'd14, 4'd15};
    wait_for(4, 1'b1, "ch0_first", dt); chk("ch0_first_dt", dt, 8);
    wait_for(4, 1'b0, "ch0_fall", dt);  chk("ch0_half", dt, 8);
    wait_for(5, 1'b1, "ch1_sync", dt);
    wait_for(5, 1'b0, "ch1_lo", dt);    chk("ch1_width", dt, 1);
    wait_for(5, 1'b1, "ch1_next", dt);  chk("ch1_gap", dt, 15);
    wait_for(4, ~obs[4], "spd_align", dt);
    repeat (3) cyc();
    speed[3:0] = 4'd14;
    wait_for(4, ~obs[4], "spd_cur", dt);  chk("spd_cur_dt", dt, 5);
    wait_for(4, ~obs[4], "spd_next", dt); chk("spd_next_dt", dt, 16);
    speed[3:0] = 4'd15;
    wait_for(4, 1'b1, "mode_align", dt);
    mode[0] = 1'b1;
    cyc();
    chk("pulse_force", obs[4], 0);
    mode[0] = 1'b0;
    repeat (3) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_clr", obs, 0);
    wait_for(4, 1'b1, "sync_e", dt); chk("sync_dt", dt, 8);
    en[2] = 1'b0;
    cyc();
    chk("en2_off", {obs[6], obs[2]}, 0);
    wait_for(4, ~obs[4], "keep_a", dt);
    wait_for(4, ~obs[4], "keep_b", dt); chk("ch0_keep", dt, 8);
    speed[11:8] = 4'd0;
    repeat (3) cyc();
    en[2] = 1'b1;
    cyc();
    wait_for(2, 1'b1, "w2", dt); chk("w2_dt", dt, 128);
    wait_for(4, ~obs[4], "rst_align", dt);
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid", obs, 0);
    acc = 1'b0;
    repeat (6) begin cyc(); acc |= obs[0]; end
    chk("no_wrap0", acc, 0);
    repeat (20) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
